spi_device_core: RTL and testbench

SPI device-side (slave) core: the far end of the SPI host link, receiving serial characters from an external master on `sclk_i`/`ss_ni` and returning data on `sd_o`. Oversamples the SPI pins in the `clk_i` domain, shifts characters of 1–32 bits, and exposes single-entry RX/TX buffers, control and status through the same register-bus port style as the host core. Sits behind the peripheral bus bridge next to `spi_core`.

---
 rtl/spi_device_pkg.sv | 31 +++
 rtl/spi_device_core_if.sv | 13 +
 rtl/spi_device_shift.sv | 111 +++++++++++
 rtl/spi_device_core.sv | 141 ++++++++++++++
 tb/tb_spi_device_core.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_device_pkg.sv
// Shared constants and types for the SPI device core and its shift engine.
package spi_device_pkg;

    localparam int SPI_DEV_MAX_CHAR = 32;

    // Register offsets, selected by addr_i[4:2]
    localparam logic [2:0] REG_RX     = 3'd0;
    localparam logic [2:0] REG_TX     = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;

    // CTRL bit positions ([4:0] is CHAR_LEN)
    localparam int CTRL_RX_NEG = 5;
    localparam int CTRL_TX_NEG = 6;
    localparam int CTRL_LSB    = 7;
    localparam int CTRL_IE     = 8;
    localparam int CTRL_EN     = 9;

    // STATUS bit positions
    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_UNDERRUN = 3;
    localparam int ST_ACTIVE   = 4;

    typedef enum logic {
        DEV_IDLE   = 1'b0,
        DEV_ACTIVE = 1'b1
    } dev_state_e;

endpackage

// File: rtl/spi_device_core_if.sv
// Register-bus port of the SPI device core.
interface spi_device_core_if;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        we_i;
    logic        re_i;
    logic [31:0] rdata_o;
    logic        error_o;

    modport master (output addr_i, wdata_i, be_i, we_i, re_i, input rdata_o, error_o);
    modport slave  (input addr_i, wdata_i, be_i, we_i, re_i, output rdata_o, error_o);
endinterface

// File: rtl/spi_device_shift.sv
// Pin synchronizers, registered edge detection, TX/RX shifters and bit counter.
module spi_device_shift
    import spi_device_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sclk_i,
    input  logic        ss_ni,
    input  logic        sd_i,
    input  logic        active,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic [4:0]  char_len,
    input  logic        rx_negedge,
    input  logic        tx_negedge,
    input  logic        lsb_first,
    output logic        ss_fall,
    output logic        ss_high,
    output logic        char_done,
    output logic [31:0] rx_word,
    output logic        sd_bit
);
    logic [SYNC_STAGES-1:0]      sclk_sync, ss_sync, sd_sync;
    logic                        sclk_d, sclk_rise, sclk_fall, sd_q;
    logic [SPI_DEV_MAX_CHAR-1:0] tx_sh, rx_sh;
    logic [5:0]                  bit_cnt, cnt_inc, char_bits;
    logic [4:0]                  top_bit;
    logic                        sampled, sample_edge, drive_edge;

    // CHAR_LEN of 0 means a full 32-bit character; top_bit wraps to 31 likewise
    assign char_bits   = (char_len == 5'd0) ? 6'd32 : {1'b0, char_len};
    assign top_bit     = char_len - 5'd1;
    assign sample_edge = active & (rx_negedge ? sclk_fall : sclk_rise);
    assign drive_edge  = active & (tx_negedge ? sclk_fall : sclk_rise);
    assign cnt_inc     = bit_cnt + 6'd1;
    assign char_done   = sample_edge & (cnt_inc == char_bits);
    assign sd_bit      = active & (lsb_first ? tx_sh[0] : tx_sh[top_bit]);

    // Shift-in value including the bit on this sample edge, right-justified
    always_comb begin
        rx_word = {rx_sh[SPI_DEV_MAX_CHAR-2:0], sd_q};
        if (lsb_first) begin
            rx_word          = rx_sh >> 1;
            rx_word[top_bit] = sd_q;
        end
    end

    // Multi-stage synchronizers on the async SPI pins; ss idles deselected
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            sd_sync   <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_ni};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sd_i};
        end
    end

    // Registered edge pulses; sd_q is delayed to line up with the sclk pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_d    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ss_high   <= 1'b1;
            ss_fall   <= 1'b0;
            sd_q      <= 1'b0;
        end else begin
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
            sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_d;
            ss_high   <= ss_sync[SYNC_STAGES-1];
            ss_fall   <= ~ss_sync[SYNC_STAGES-1] & ss_high;
            sd_q      <= sd_sync[SYNC_STAGES-1];
        end
    end

    // Character engine: load wins, idle discards everything, else shift on edges
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            sampled <= 1'b0;
        end else if (load) begin
            tx_sh   <= load_word;
            rx_sh   <= '0;
            bit_cnt <= '0;
            sampled <= 1'b0;
        end else if (!active) begin
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            sampled <= 1'b0;
        end else begin
            // Drive edges before the first sample of a char keep the first bit up
            if (drive_edge && sampled)
                tx_sh <= lsb_first ? (tx_sh >> 1) : (tx_sh << 1);
            if (sample_edge) begin
                rx_sh   <= rx_word;
                bit_cnt <= cnt_inc;
                sampled <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_device_core.sv
// SPI device core: register file, single-entry RX/TX buffers and link FSM.
module spi_device_core
    import spi_device_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    spi_device_core_if.slave bus,
    output logic             intr_rx_o,
    output logic             intr_tx_o,
    input  logic             sclk_i,
    input  logic             ss_ni,
    input  logic             sd_i,
    output logic             sd_o,
    output logic             sd_oe
);
    dev_state_e  state_q, state_d;
    logic [9:0]  ctrl_q;
    logic [31:0] tx_buf_q, rx_buf_q, rdata_q, rd_val, load_word, rx_word;
    logic        tx_full_q, rx_valid_q, overrun_q, underrun_q, error_q;
    logic        ss_fall, ss_high, char_done, enter, load, active;
    logic        wr_tx, wr_ctrl, wr_stat, rd_rx;
    logic [2:0]  reg_off;
    logic        unused_addr;

    assign reg_off     = bus.addr_i[4:2];
    assign unused_addr = ^{bus.addr_i[7:5], bus.addr_i[1:0]};
    assign active      = (state_q == DEV_ACTIVE);
    assign wr_tx       = bus.we_i && (reg_off == REG_TX);
    assign wr_ctrl     = bus.we_i && (reg_off == REG_CTRL);
    assign wr_stat     = bus.we_i && (reg_off == REG_STATUS);
    assign rd_rx       = bus.re_i && (reg_off == REG_RX);
    assign load        = enter | char_done;
    assign load_word   = tx_full_q ? tx_buf_q : '0;
    assign bus.rdata_o = rdata_q;
    assign bus.error_o = error_q;
    assign sd_oe       = active;

    spi_device_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sclk_i     (sclk_i),
        .ss_ni      (ss_ni),
        .sd_i       (sd_i),
        .active     (active),
        .load       (load),
        .load_word  (load_word),
        .char_len   (ctrl_q[4:0]),
        .rx_negedge (ctrl_q[CTRL_RX_NEG]),
        .tx_negedge (ctrl_q[CTRL_TX_NEG]),
        .lsb_first  (ctrl_q[CTRL_LSB]),
        .ss_fall    (ss_fall),
        .ss_high    (ss_high),
        .char_done  (char_done),
        .rx_word    (rx_word),
        .sd_bit     (sd_o)
    );

    // Link FSM next state; entry also triggers the first character load
    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        case (state_q)
            DEV_IDLE: if (ctrl_q[CTRL_EN] && ss_fall) begin
                state_d = DEV_ACTIVE;
                enter   = 1'b1;
            end
            DEV_ACTIVE: if (ss_high || !ctrl_q[CTRL_EN]) state_d = DEV_IDLE;
        endcase
    end

    // Link FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= DEV_IDLE;
        else       state_q <= state_d;
    end

    // Read mux; write-only and unmapped offsets read as zero
    always_comb begin
        rd_val = '0;
        case (reg_off)
            REG_RX:     rd_val = rx_buf_q;
            REG_CTRL:   rd_val = {22'b0, ctrl_q};
            REG_STATUS: rd_val = {27'b0, active, underrun_q, overrun_q, tx_full_q, rx_valid_q};
            default:    ;
        endcase
    end

    // Registers and buffers; hardware sets come last so they beat bus clears
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q     <= '0;
            tx_buf_q   <= '0;
            rx_buf_q   <= '0;
            rdata_q    <= '0;
            tx_full_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            error_q    <= 1'b0;
            intr_rx_o  <= 1'b0;
            intr_tx_o  <= 1'b0;
        end else begin
            intr_rx_o <= 1'b0;
            intr_tx_o <= 1'b0;
            error_q   <= (bus.we_i || bus.re_i) && (reg_off > REG_STATUS);
            if (bus.re_i) rdata_q <= rd_val;
            if (wr_ctrl && !active) begin
                if (bus.be_i[0]) ctrl_q[7:0] <= bus.wdata_i[7:0];
                if (bus.be_i[1]) ctrl_q[9:8] <= bus.wdata_i[9:8];
            end
            if (wr_stat && bus.be_i[0]) begin
                if (bus.wdata_i[ST_OVERRUN])  overrun_q  <= 1'b0;
                if (bus.wdata_i[ST_UNDERRUN]) underrun_q <= 1'b0;
            end
            if (rd_rx) rx_valid_q <= 1'b0;
            if (load) begin
                tx_full_q <= 1'b0;
                if (tx_full_q) intr_tx_o  <= ctrl_q[CTRL_IE];
                else           underrun_q <= 1'b1;
            end
            // Decided on the old TX_FULL: a write racing a load of a full buffer is dropped
            if (wr_tx && !tx_full_q) begin
                for (int b = 0; b < 4; b++)
                    if (bus.be_i[b]) tx_buf_q[b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
                tx_full_q <= 1'b1;
            end
            if (char_done) begin
                if (!rx_valid_q) begin
                    rx_buf_q   <= rx_word;
                    rx_valid_q <= 1'b1;
                    intr_rx_o  <= ctrl_q[CTRL_IE];
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_device_core.sv
// Directed bench: a bit-banged SPI master plus a transaction-level register model.
module tb_spi_device_core;
    localparam int HALF = 8;  // sclk half period in clk cycles

    logic clk = 1'b0, rst = 1'b1;
    logic sclk_i = 1'b0, ss_ni = 1'b1, sd_i = 1'b0;
    logic sd_o, sd_oe, intr_rx_o, intr_tx_o;

    spi_device_core_if bus();

    spi_device_core #(.SYNC_STAGES(2)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .intr_rx_o (intr_rx_o),
        .intr_tx_o (intr_tx_o),
        .sclk_i    (sclk_i),
        .ss_ni     (ss_ni),
        .sd_i      (sd_i),
        .sd_o      (sd_o),
        .sd_oe     (sd_oe)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_pass = 0;
    int n_irx = 0, n_itx = 0, e_irx = 0, e_itx = 0;

    // Register model
    logic [9:0]  m_ctrl = '0;
    logic [31:0] m_tx = '0, m_rx = '0, m_shift = '0;
    logic        m_txf = 0, m_rxv = 0, m_ovr = 0, m_und = 0, m_active = 0;

    // Pending read check handed to the compare process
    logic        rd_pend = 0, rd_err = 0, irx_prev = 0, itx_prev = 0;
    logic [31:0] rd_exp = '0, last_miso = '0;
    string       rd_name = "";

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    function automatic int m_len();
        return (m_ctrl[4:0] == 5'd0) ? 32 : int'(m_ctrl[4:0]);
    endfunction

    function automatic logic [31:0] msk(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    function automatic logic [31:0] m_reg(input logic [2:0] off);
        case (off)
            3'd0:    return m_rx;
            3'd2:    return {22'b0, m_ctrl};
            3'd3:    return {27'b0, m_active, m_und, m_ovr, m_txf, m_rxv};
            default: return 32'h0;
        endcase
    endfunction

    // Character load: TX buffer goes to the line, or zeros with an underrun
    task automatic m_load();
        if (m_txf) begin
            m_shift = m_tx;
            m_txf   = 0;
            if (m_ctrl[8]) e_itx++;
        end else begin
            m_shift = 32'h0;
            m_und   = 1;
        end
    endtask

    task automatic m_reset();
        m_ctrl = '0; m_tx = '0; m_rx = '0; m_shift = '0;
        m_txf = 0; m_rxv = 0; m_ovr = 0; m_und = 0; m_active = 0;
    endtask

    // Compare process: read data/error one cycle after re, interrupt widths, idle MISO
    always @(posedge clk) begin
        #1;
        if (rd_pend) begin
            chk({"rd_", rd_name}, bus.rdata_o, rd_exp);
            chk({"err_", rd_name}, {31'b0, bus.error_o}, {31'b0, rd_err});
            rd_pend = 0;
        end
        if (intr_rx_o) begin
            n_irx++;
            chk("intr_rx_width", {31'b0, irx_prev}, 32'h0);
        end
        if (intr_tx_o) begin
            n_itx++;
            chk("intr_tx_width", {31'b0, itx_prev}, 32'h0);
        end
        if (!sd_oe && sd_o) chk("sd_o_idle", {31'b0, sd_o}, 32'h0);
        irx_prev = intr_rx_o;
        itx_prev = intr_tx_o;
    end

    task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus.addr_i = {3'b0, off, 2'b0}; bus.wdata_i = d; bus.be_i = be; bus.we_i = 1;
        case (off)
            3'd1: if (!m_txf) begin
                for (int b = 0; b < 4; b++) if (be[b]) m_tx[b*8 +: 8] = d[b*8 +: 8];
                m_txf = 1;
            end
            3'd2: if (!m_active) begin
                if (be[0]) m_ctrl[7:0] = d[7:0];
                if (be[1]) m_ctrl[9:8] = d[9:8];
            end
            3'd3: if (be[0]) begin
                if (d[2]) m_ovr = 0;
                if (d[3]) m_und = 0;
            end
            default: ;
        endcase
        @(negedge clk);
        bus.we_i = 0;
    endtask

    task automatic rd(input logic [2:0] off, input string name);
        @(negedge clk);
        bus.addr_i = {3'b0, off, 2'b0}; bus.re_i = 1;
        rd_exp = m_reg(off); rd_err = (off > 3'd3); rd_name = name; rd_pend = 1;
        if (off == 3'd0) m_rxv = 0;
        @(negedge clk);
        bus.re_i = 0;
    endtask

    task automatic ss_lo();
        ss_ni = 0;
        repeat (12) @(negedge clk);
        if (m_ctrl[9]) begin
            m_active = 1;
            m_load();
        end
    endtask

    task automatic ss_hi();
        repeat (8) @(negedge clk);
        ss_ni = 1;
        repeat (12) @(negedge clk);
        m_active = 0;
    endtask

    // Mode-0 master: drive MOSI while sclk low, sample MISO on the rising edge
    task automatic spi_char(input int n, input logic lsb, input logic [31:0] mosi,
                            output logic [31:0] miso);
        miso = '0;
        for (int i = 0; i < n; i++) begin
            int b;
            b = lsb ? i : n - 1 - i;
            sd_i = mosi[b];
            repeat (HALF) @(negedge clk);
            miso[b] = sd_o;
            sclk_i = 1;
            repeat (HALF) @(negedge clk);
            sclk_i = 0;
        end
    endtask

    // One full character: check MISO against the loaded word, then update RX state
    task automatic xfer(input logic [31:0] mosi, input string name);
        logic [31:0] miso;
        int n;
        n = m_len();
        spi_char(n, m_ctrl[7], mosi, miso);
        last_miso = miso;
        chk({"miso_", name}, miso, m_shift & msk(n));
        if (!m_rxv) begin
            m_rx = mosi & msk(n);
            m_rxv = 1;
            if (m_ctrl[8]) e_irx++;
        end else begin
            m_ovr = 1;
        end
        m_load();
    endtask

    initial begin
        bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0; bus.we_i = 0; bus.re_i = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_rdata", bus.rdata_o, 32'h0);
        chk("rst_error", {31'b0, bus.error_o}, 32'h0);
        chk("rst_sd", {30'b0, sd_oe, sd_o}, 32'h0);
        chk("rst_intr", {30'b0, intr_rx_o, intr_tx_o}, 32'h0);
        rd(3'd3, "rst_status");
        rd(3'd2, "rst_ctrl");
        rd(3'd5, "unmapped");

        // Mode 0, 8-bit, MSB first, TX 0xA5 vs master 0x3C
        wr(3'd2, 32'h348, 4'h3);
        wr(3'd1, 32'hA5, 4'hF);
        rd(3'd3, "t1_status_pre");
        ss_lo();
        xfer(32'h3C, "t1");
        ss_hi();
        chk("t1_miso_lit", last_miso, 32'hA5);
        rd(3'd3, "t1_status");
        rd(3'd0, "t1_rx");
        chk("t1_rx_lit", bus.rdata_o, 32'h3C);
        chk("t1_irx_lit", n_irx, 1);
        chk("t1_itx_lit", n_itx, 1);
        wr(3'd3, 32'hC, 4'h1);

        // 32-bit LSB first
        wr(3'd2, 32'h3C0, 4'h3);
        wr(3'd1, 32'hDEADBEEF, 4'hF);
        ss_lo();
        xfer(32'h12345678, "t2");
        ss_hi();
        rd(3'd0, "t2_rx");
        chk("t2_rx_lit", bus.rdata_o, 32'h12345678);
        wr(3'd3, 32'hC, 4'h1);

        // Two chars without reading RX: overrun, then W1C
        wr(3'd2, 32'h348, 4'h3);
        wr(3'd1, 32'h5A, 4'hF);
        ss_lo();
        xfer(32'h11, "t3a");
        xfer(32'h22, "t3b");
        ss_hi();
        rd(3'd3, "t3_status");
        chk("t3_status_lit", bus.rdata_o, 32'hD);
        rd(3'd0, "t3_rx");
        wr(3'd3, 32'h4, 4'h1);
        rd(3'd3, "t3_status_w1c");
        wr(3'd3, 32'h8, 4'h1);

        // No TX write: zeros on the line, underrun
        ss_lo();
        xfer(32'h81, "t4");
        ss_hi();
        rd(3'd3, "t4_status");
        rd(3'd0, "t4_rx");
        wr(3'd3, 32'h8, 4'h1);

        // Abort after 5 bits, then a clean char
        wr(3'd1, 32'h33, 4'hF);
        ss_lo();
        spi_char(5, 1'b0, 32'h1F, last_miso);
        ss_hi();
        rd(3'd3, "t5_status");
        chk("t5_status_lit", bus.rdata_o, 32'h0);
        wr(3'd1, 32'hC3, 4'hF);
        ss_lo();
        xfer(32'h96, "t5");
        ss_hi();
        rd(3'd0, "t5_rx");
        chk("t5_rx_lit", bus.rdata_o, 32'h96);
        wr(3'd3, 32'hC, 4'h1);

        // Second TX write dropped; CTRL write ignored while active
        wr(3'd1, 32'h11, 4'hF);
        wr(3'd1, 32'h22, 4'hF);
        ss_lo();
        wr(3'd2, 32'h341, 4'h3);
        rd(3'd2, "t6_ctrl");
        rd(3'd3, "t6_status_active");
        xfer(32'h5A, "t6");
        ss_hi();
        chk("t6_miso_lit", last_miso, 32'h11);
        rd(3'd0, "t6_rx");
        wr(3'd3, 32'hC, 4'h1);

        // Reset mid-transfer
        wr(3'd1, 32'h77, 4'hF);
        ss_lo();
        spi_char(3, 1'b0, 32'h5, last_miso);
        chk("t7_oe_active", {31'b0, sd_oe}, 32'h1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("t7_oe_reset", {30'b0, sd_oe, sd_o}, 32'h0);
        rst = 0;
        m_reset();
        ss_ni = 1;
        rd(3'd3, "t7_status");
        rd(3'd2, "t7_ctrl");

        chk("irx_total", n_irx, e_irx);
        chk("itx_total", n_itx, e_itx);
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
